// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The ovf signal is present only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      input  ovf,
`endif
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      output ovf,
`endif
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock behind a start/done handshake.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             d_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      diff_sh_d = diff_sh_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      ovf_d     = ovf_q;
`endif
      d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = StRun;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
`endif
            end
         end
         StRun: begin
            // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            diff_sh_d = {d_bit, diff_sh_q[WIDTH-1:1]};
            a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
            borrow_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
            cnt_d     = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFin;
            end
         end
         StFin: begin
            diff_d  = diff_sh_q;
            bout_d  = borrow_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_d   = (a_msb_q ^ b_msb_q) & (diff_sh_q[WIDTH-1] ^ a_msb_q);
`endif
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         diff_sh_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         borrow_q  <= 1'b0;
         bout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q   <= 1'b0;
         b_msb_q   <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         diff_sh_q <= diff_sh_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         borrow_q  <= borrow_d;
         bout_q    <= bout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q   <= a_msb_d;
         b_msb_q   <= b_msb_d;
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4; covers ovf when
// SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One start pulse, then wait (bounded) for done and check result and timing.
   task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ediff,
                        input logic ebout, input logic eovf, input string tag);
      int n;
      int nb;
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      tick();
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      n  = 0;
      nb = 0;
      while (!bus.done && n < 20) begin
         if (bus.busy) nb++;
         n++;
         tick();
      end
      chk({tag, " latency"}, 32'(n), 32'd5);
      chk({tag, " busy_cycles"}, 32'(nb), 32'd5);
      chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({tag, " diff"}, 32'(bus.diff), 32'(ediff));
      chk({tag, " bout"}, 32'(bus.bout), 32'(ebout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, " ovf"}, 32'(bus.ovf), 32'(eovf));
`else
      if (eovf === 1'bx) $display("unexpected x");
`endif
      tick();
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, " diff_held"}, 32'(bus.diff), 32'(ediff));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int ndone;
      logic [3:0] ea, eb, ed;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst diff", 32'(bus.diff), 32'd0);
      chk("rst bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("rst ovf", 32'(bus.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      do_op(4'd9, 4'd3, 4'd6,  1'b0, 1'b1, "9-3");
      do_op(4'd0, 4'd1, 4'd15, 1'b1, 1'b0, "0-1");
      do_op(4'd5, 4'd5, 4'd0,  1'b0, 1'b0, "5-5");

      // Start pulses while busy must be ignored.
      bus.start = 1'b1;
      bus.a     = 4'd12;
      bus.b     = 4'd5;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      bus.a     = 4'd1;
      bus.b     = 4'd15;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("ign done", 32'(bus.done), 32'd1);
      chk("ign diff", 32'(bus.diff), 32'd7);
      chk("ign bout", 32'(bus.bout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("ign extra_done", 32'(ndone), 32'd0);
      chk("ign idle", 32'(bus.busy), 32'd0);
      chk("ign diff_held", 32'(bus.diff), 32'd7);

      // Reset mid-RUN aborts without a done pulse.
      bus.start = 1'b1;
      bus.a     = 4'd2;
      bus.b     = 4'd1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort diff", 32'(bus.diff), 32'd0);
      chk("abort bout", 32'(bus.bout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done || bus.busy) ndone++;
      end
      chk("abort no_activity", 32'(ndone), 32'd0);
      do_op(4'd3, 4'd9, 4'd10, 1'b1, 1'b1, "3-9");

`ifdef SERIAL_SUBTRACTOR_OVF_EN
      do_op(4'd7, 4'd15, 4'd8, 1'b1, 1'b1, "ovf 7-15");
      do_op(4'd8, 4'd1,  4'd7, 1'b0, 1'b1, "ovf 8-1");
      do_op(4'd6, 4'd2,  4'd4, 1'b0, 1'b0, "ovf 6-2");
`endif

      // All 256 pairs back-to-back with start held high.
      bus.start = 1'b1;
      bus.a     = 4'd0;
      bus.b     = 4'd0;
      tick();
      for (int i = 0; i < 256; i++) begin
         ea = 4'(i >> 4);
         eb = 4'(i);
         ed = ea - eb;
         n  = 0;
         while (!bus.done && n < 20) begin
            n++;
            tick();
         end
         chk("exh period", 32'(n + 1), 32'd6);
         chk("exh diff", 32'(bus.diff), 32'(ed));
         chk("exh bout", 32'(bus.bout), 32'(ea < eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         chk("exh ovf", 32'(bus.ovf), 32'((ea[3] ^ eb[3]) & (ed[3] ^ ea[3])));
`endif
         if (i < 255) begin
            bus.a = 4'((i + 1) >> 4);
            bus.b = 4'(i + 1);
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      tick();
      chk("exh idle", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
